onc_16_dmem: RTL and testbench



---
 rtl/onc_16_dmem_pkg.sv | 63 ++++++
 rtl/onc_16_tx_fifo.sv | 60 ++++++
 rtl/onc_16_dmem.sv | 171 +++++++++++++++++
 tb/tb_onc_16_dmem.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onc_16_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onc_16_dmem_pkg
// Description : Shared constants and address decode for the ONC-16 data
//               memory responder (MMIO map, register bit positions).
// Revision    : 1.0 - initial release
// ============================================================================
package onc_16_dmem_pkg;

  localparam int c_word_w = 16;

  // MMIO word addresses
  localparam logic [15:0] c_mmio_gpio_out   = 16'hFF00;
  localparam logic [15:0] c_mmio_gpio_in    = 16'hFF01;
  localparam logic [15:0] c_mmio_timer_cnt  = 16'hFF02;
  localparam logic [15:0] c_mmio_timer_ctrl = 16'hFF03;
  localparam logic [15:0] c_mmio_tx_data    = 16'hFF04;
  localparam logic [15:0] c_mmio_tx_status  = 16'hFF05;

  // TX_STATUS bit positions
  localparam int c_stat_full    = 0;
  localparam int c_stat_empty   = 1;
  localparam int c_stat_ovf     = 2;
  localparam int c_stat_cnt_lsb = 4;
  localparam int c_stat_cnt_w   = 8;

  // TIMER_CTRL bit positions
  localparam int c_ctrl_en   = 0;
  localparam int c_ctrl_wrap = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_TIMER_CNT,
    REG_TIMER_CTRL,
    REG_TX_DATA,
    REG_TX_STATUS
  } region_e;

  // RAM sits at the bottom of the map; everything else is either one of the
  // six MMIO words or unmapped.
  function automatic region_e decode_addr(input logic [15:0] addr, input int ram_aw);
    region_e r;
    if ((32'(addr) >> ram_aw) == 32'd0) begin
      r = REG_RAM;
    end else begin
      case (addr)
        c_mmio_gpio_out:   r = REG_GPIO_OUT;
        c_mmio_gpio_in:    r = REG_GPIO_IN;
        c_mmio_timer_cnt:  r = REG_TIMER_CNT;
        c_mmio_timer_ctrl: r = REG_TIMER_CTRL;
        c_mmio_tx_data:    r = REG_TX_DATA;
        c_mmio_tx_status:  r = REG_TX_STATUS;
        default:           r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onc_16_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : onc_16_tx_fifo
// Description : Power-of-two depth word FIFO feeding the external serialiser.
//               Pointers carry one extra wrap bit so full and empty are
//               distinguished without a separate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module onc_16_tx_fifo
  import onc_16_dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [c_word_w-1:0]        push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [c_word_w-1:0]        head
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]         r_wr_ptr;
  logic [c_aw:0]         r_rd_ptr;
  logic [c_word_w-1:0]   r_mem [DEPTH];
  logic                  w_do_pop;
  logic                  w_do_push;

  assign count = r_wr_ptr - r_rd_ptr;
  assign full  = (count == (c_aw+1)'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is only taken when a pop frees the slot this edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign head = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  // Pointer update; reset discards any queued words.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; empty masks stale contents on the head output.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/onc_16_dmem.sv
`default_nettype none
// ============================================================================
// Module      : onc_16_dmem
// Description : ONC-16 data-memory responder. Word RAM plus an MMIO page with
//               GPIO out/in, a prescaled timer and a TX FIFO. Reads are
//               combinational so the core can write back in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module onc_16_dmem
  import onc_16_dmem_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int TX_DEPTH = 4,
  parameter int PRESCALE = 1
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic [15:0] dmem_addr,
  input  logic [15:0] dmem_dout,
  input  logic        dmem_we,
  output logic [15:0] dmem_din,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int c_fifo_cw = $clog2(TX_DEPTH) + 1;
  localparam int c_ps_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  region_e               w_region;
  logic                  w_wr_ram;
  logic                  w_wr_gpio;
  logic                  w_wr_cnt;
  logic                  w_wr_ctrl;
  logic                  w_wr_tx;
  logic                  w_wr_status;
  logic                  w_pre_last;
  logic                  w_wrap_set;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_fifo_cw-1:0]  w_count;
  logic [15:0]           w_status;

  logic [15:0]           r_ram [2**RAM_AW];
  logic [15:0]           r_gpio_out;
  logic [15:0]           r_gpio_sync1;
  logic [15:0]           r_gpio_sync2;
  logic [15:0]           r_cnt;
  logic [c_ps_w-1:0]     r_pre;
  logic                  r_en;
  logic                  r_wrap;
  logic                  r_ovf;

  assign w_region    = decode_addr(dmem_addr, RAM_AW);
  assign w_wr_ram    = dmem_we && (w_region == REG_RAM);
  assign w_wr_gpio   = dmem_we && (w_region == REG_GPIO_OUT);
  assign w_wr_cnt    = dmem_we && (w_region == REG_TIMER_CNT);
  assign w_wr_ctrl   = dmem_we && (w_region == REG_TIMER_CTRL);
  assign w_wr_tx     = dmem_we && (w_region == REG_TX_DATA);
  assign w_wr_status = dmem_we && (w_region == REG_TX_STATUS);

  assign gpio_out = r_gpio_out;
  assign tx_valid = !w_empty;
  assign w_pop    = tx_valid && tx_ready;

  // Word RAM: asynchronous read, write lands on the sampling edge.
  always_ff @(posedge clock) begin
    if (w_wr_ram) r_ram[dmem_addr[RAM_AW-1:0]] <= dmem_dout;
  end

  // GPIO output register and two-flop input synchroniser.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_gpio_out   <= '0;
      r_gpio_sync1 <= '0;
      r_gpio_sync2 <= '0;
    end else begin
      if (w_wr_gpio) r_gpio_out <= dmem_dout;
      r_gpio_sync1 <= gpio_in;
      r_gpio_sync2 <= r_gpio_sync1;
    end
  end

  assign w_pre_last = (r_pre == c_ps_w'(PRESCALE - 1));
  // A CPU write to CNT suppresses the increment, so it cannot wrap that edge.
  assign w_wrap_set = !w_wr_cnt && r_en && w_pre_last && (r_cnt == 16'hFFFF);

  // Timer: prescaler, counter, enable and sticky wrap (set beats clear).
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_en   <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (w_wr_cnt) begin
        r_cnt <= dmem_dout;
        r_pre <= '0;
      end else if (r_en) begin
        if (w_pre_last) begin
          r_pre <= '0;
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end
      if (w_wr_ctrl) r_en <= dmem_dout[c_ctrl_en];
      if (w_wrap_set) begin
        r_wrap <= 1'b1;
      end else if (w_wr_ctrl && dmem_dout[c_ctrl_wrap]) begin
        r_wrap <= 1'b0;
      end
    end
  end

  // Sticky overflow: a push is lost only when full and nothing drains.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
    end else if (w_wr_tx && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_wr_status && dmem_dout[c_stat_ovf]) begin
      r_ovf <= 1'b0;
    end
  end

  onc_16_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .n_rst     (n_rst),
    .push      (w_wr_tx),
    .push_data (dmem_dout),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (tx_data)
  );

  // TX_STATUS word assembled from registered FIFO state and the OVF flag.
  always_comb begin
    w_status = '0;
    w_status[c_stat_full]  = w_full;
    w_status[c_stat_empty] = w_empty;
    w_status[c_stat_ovf]   = r_ovf;
    w_status[c_stat_cnt_lsb +: c_stat_cnt_w] = c_stat_cnt_w'(w_count);
  end

  // Read mux; TX_DATA, unmapped addresses and reserved bits return zero.
  always_comb begin
    dmem_din = '0;
    case (w_region)
      REG_RAM:        dmem_din = r_ram[dmem_addr[RAM_AW-1:0]];
      REG_GPIO_OUT:   dmem_din = r_gpio_out;
      REG_GPIO_IN:    dmem_din = r_gpio_sync2;
      REG_TIMER_CNT:  dmem_din = r_cnt;
      REG_TIMER_CTRL: begin
        dmem_din[c_ctrl_en]   = r_en;
        dmem_din[c_ctrl_wrap] = r_wrap;
      end
      REG_TX_STATUS:  dmem_din = w_status;
      default:        dmem_din = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_onc_16_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_onc_16_dmem
// Description : Self-checking bench for onc_16_dmem with a transaction-level
//               reference model (queue FIFO, array RAM, integer timer).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onc_16_dmem;

  localparam int RAM_AW   = 10;
  localparam int TX_DEPTH = 4;
  localparam int PRESCALE = 1;

  logic        clock = 1'b0;
  logic        n_rst;
  logic [15:0] dmem_addr, dmem_dout, dmem_din;
  logic        dmem_we;
  logic [15:0] gpio_in, gpio_out, tx_data;
  logic        tx_valid, tx_ready;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] ram_m [int];
  logic [15:0] gpio_out_m, s1_m, s2_m, cnt_m;
  int          pre_m;
  bit          en_m, wrap_m, ovf_m;
  logic [15:0] q [$];

  onc_16_dmem #(.RAM_AW(RAM_AW), .TX_DEPTH(TX_DEPTH), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .n_rst(n_rst), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout),
    .dmem_we(dmem_we), .dmem_din(dmem_din), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #10 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    if (a < 16'(1 << RAM_AW)) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'hxxxx;
    case (a)
      16'hFF00: return gpio_out_m;
      16'hFF01: return s2_m;
      16'hFF02: return cnt_m;
      16'hFF03: return {14'b0, wrap_m, en_m};
      16'hFF05: return {4'b0, 8'(q.size()), 1'b0, ovf_m, q.size() == 0, q.size() == TX_DEPTH};
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic void model_reset();
    gpio_out_m = 0; s1_m = 0; s2_m = 0; cnt_m = 0; pre_m = 0;
    en_m = 0; wrap_m = 0; ovf_m = 0; q.delete();
  endfunction

  // Behaviour of one clock edge in terms of the register map.
  function automatic void model_edge(input logic we, input logic [15:0] a, input logic [15:0] d,
                                     input logic ready);
    bit pop, wrap_set;
    pop = (q.size() > 0) && ready;
    wrap_set = 0;
    if (pop) void'(q.pop_front());
    if (we && a == 16'hFF04) begin
      if (q.size() < TX_DEPTH) q.push_back(d);
      else ovf_m = 1;
    end
    if (we && a == 16'hFF05 && d[2] && !(we && a == 16'hFF04 && q.size() >= TX_DEPTH && !pop)) ovf_m = 0;
    if (we && a == 16'hFF02) begin
      cnt_m = d; pre_m = 0;
    end else if (en_m) begin
      pre_m++;
      if (pre_m == PRESCALE) begin
        pre_m = 0;
        if (cnt_m == 16'hFFFF) wrap_set = 1;
        cnt_m = cnt_m + 16'd1;
      end
    end
    if (we && a == 16'hFF03) begin
      en_m = d[0];
      if (d[1]) wrap_m = 0;
    end
    if (wrap_set) wrap_m = 1;
    if (we && a == 16'hFF00) gpio_out_m = d;
    if (we && a < 16'(1 << RAM_AW)) ram_m[int'(a)] = d;
    s2_m = s1_m;
    s1_m = gpio_in;
  endfunction

  task automatic cycle(input logic we, input logic [15:0] a, input logic [15:0] d, input logic ready);
    dmem_we = we; dmem_addr = a; dmem_dout = d; tx_ready = ready;
    #1;
    model_edge(we, a, d, ready);
    @(posedge clock);
    #1;
    dmem_we = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; dmem_we = 0; dmem_addr = 0; dmem_dout = 0; gpio_in = 0; tx_ready = 0;
    repeat (3) @(posedge clock);
    #3 n_rst = 1'b1;
    model_reset();
    #1;
    checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL rst_gpio_out actual=%h expected=0000", gpio_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid actual=%b expected=0", tx_valid); end
    checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL rst_tx_data actual=%h expected=0000", tx_data); end
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0002) begin errors++; $display("FAIL rst_status actual=%h expected=0002", dmem_din); end
    dmem_addr = 16'hFF02; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL rst_cnt actual=%h expected=0000", dmem_din); end
    dmem_addr = 16'hFF03; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL rst_ctrl actual=%h expected=0000", dmem_din); end
  endtask

  task automatic test_ram();
    logic [15:0] a, d;
    cycle(1, 16'h0005, 16'h1234, 0);
    dmem_addr = 16'h0005; #1;
    checks++; if (dmem_din !== 16'h1234) begin errors++; $display("FAIL ram_rd5 actual=%h expected=1234", dmem_din); end
    dmem_addr = 16'hFE00; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL unmapped_rd actual=%h expected=0000", dmem_din); end
    cycle(1, 16'hFE00, 16'hBEEF, 0);
    dmem_addr = 16'hFE00; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL unmapped_wr actual=%h expected=0000", dmem_din); end
    dmem_addr = 16'h0005; #1;
    checks++; if (dmem_din !== 16'h1234) begin errors++; $display("FAIL ram_keep5 actual=%h expected=1234", dmem_din); end
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
      if (a == 16'h0005) a = 16'h0006;
      d = 16'($urandom);
      cycle(1, a, d, 0);
      dmem_addr = a; #1;
      checks++; if (dmem_din !== exp_read(a)) begin errors++; $display("FAIL ram_rand a=%h actual=%h expected=%h", a, dmem_din, exp_read(a)); end
    end
    foreach (ram_m[k]) begin
      cycle(0, 16'h0000, 16'h0000, 0);
      dmem_addr = 16'(k); #1;
      checks++; if (dmem_din !== ram_m[k]) begin errors++; $display("FAIL ram_readback a=%h actual=%h expected=%h", 16'(k), dmem_din, ram_m[k]); end
    end
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(16'h0400, 16'hFEFF));
      cycle(1, a, 16'($urandom), 0);
      dmem_addr = a; #1;
      checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL unmapped_rand a=%h actual=%h expected=0000", a, dmem_din); end
    end
  endtask

  task automatic test_gpio();
    gpio_in = 16'hA5A5;
    cycle(0, 16'hFF01, 16'h0000, 0);
    dmem_addr = 16'hFF01; #1;
    checks++; if (dmem_din !== 16'h0000 || dmem_din !== exp_read(16'hFF01)) begin errors++; $display("FAIL gpio_in_1edge actual=%h expected=0000", dmem_din); end
    cycle(0, 16'hFF01, 16'h0000, 0);
    dmem_addr = 16'hFF01; #1;
    checks++; if (dmem_din !== 16'hA5A5) begin errors++; $display("FAIL gpio_in_2edge actual=%h expected=a5a5", dmem_din); end
    cycle(1, 16'hFF00, 16'h00FF, 0);
    checks++; if (gpio_out !== 16'h00FF) begin errors++; $display("FAIL gpio_out actual=%h expected=00ff", gpio_out); end
    dmem_addr = 16'hFF00; #1;
    checks++; if (dmem_din !== 16'h00FF) begin errors++; $display("FAIL gpio_out_rd actual=%h expected=00ff", dmem_din); end
  endtask

  task automatic test_timer();
    logic [15:0] exp_cnt [8];
    logic [15:0] exp_ctl [8];
    logic        wes [8];
    logic [15:0] adrs [8];
    logic [15:0] dats [8];
    // write CNT, enable, two idle edges to wrap, W1C, reload FFFF, W1C racing a wrap, disable
    wes  = '{1, 1, 0, 0, 1, 1, 1, 1};
    adrs = '{16'hFF02, 16'hFF03, 16'h0, 16'h0, 16'hFF03, 16'hFF02, 16'hFF03, 16'hFF03};
    dats = '{16'hFFFE, 16'h0001, 16'h0, 16'h0, 16'h0003, 16'hFFFF, 16'h0003, 16'h0002};
    exp_cnt = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001};
    exp_ctl = '{16'h0000, 16'h0001, 16'h0001, 16'h0003, 16'h0001, 16'h0001, 16'h0003, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      cycle(wes[i], adrs[i], dats[i], 0);
      dmem_addr = 16'hFF02; #1;
      checks++; if (dmem_din !== exp_cnt[i] || dmem_din !== exp_read(16'hFF02)) begin errors++; $display("FAIL timer_cnt step=%0d actual=%h expected=%h", i, dmem_din, exp_cnt[i]); end
      dmem_addr = 16'hFF03; #1;
      checks++; if (dmem_din !== exp_ctl[i] || dmem_din !== exp_read(16'hFF03)) begin errors++; $display("FAIL timer_ctrl step=%0d actual=%h expected=%h", i, dmem_din, exp_ctl[i]); end
    end
    cycle(0, 16'h0000, 16'h0000, 0);
    dmem_addr = 16'hFF02; #1;
    checks++; if (dmem_din !== 16'h0001) begin errors++; $display("FAIL timer_hold actual=%h expected=0001", dmem_din); end
  endtask

  task automatic test_fifo_overflow();
    logic [15:0] w [5];
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      cycle(1, 16'hFF04, w[i], 0);
    end
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0045 || dmem_din !== exp_read(16'hFF05)) begin errors++; $display("FAIL ovf_status actual=%h expected=0045", dmem_din); end
    dmem_addr = 16'hFF04; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL tx_data_rd actual=%h expected=0000", dmem_din); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== w[i]) begin errors++; $display("FAIL drain_order i=%0d actual=%b/%h expected=1/%h", i, tx_valid, tx_data, w[i]); end
      cycle(0, 16'h0000, 16'h0000, 1);
    end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin errors++; $display("FAIL drain_empty actual=%b/%h expected=0/0000", tx_valid, tx_data); end
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0006) begin errors++; $display("FAIL drain_status actual=%h expected=0006", dmem_din); end
    cycle(1, 16'hFF05, 16'h0004, 0);
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0002) begin errors++; $display("FAIL ovf_clear actual=%h expected=0002", dmem_din); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) cycle(1, 16'hFF04, w[i], 0);
    cycle(1, 16'hFF04, w[4], 1);
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0041) begin errors++; $display("FAIL full_push_pop actual=%h expected=0041", dmem_din); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== w[i]) begin errors++; $display("FAIL fpp_order i=%0d actual=%b/%h expected=1/%h", i, tx_valid, tx_data, w[i]); end
      cycle(0, 16'h0000, 16'h0000, 1);
    end
    cycle(1, 16'hFF04, w[5], 1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== w[5]) begin errors++; $display("FAIL empty_push_pop actual=%b/%h expected=1/%h", tx_valid, tx_data, w[5]); end
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0010) begin errors++; $display("FAIL empty_push_pop_status actual=%h expected=0010", dmem_din); end
    cycle(0, 16'h0000, 16'h0000, 1);
  endtask

  task automatic test_back_to_back();
    int op;
    logic [15:0] exp_head;
    for (int i = 0; i < 150; i++) begin
      exp_head = (q.size() != 0) ? q[0] : 16'h0000;
      checks++; if (tx_valid !== (q.size() != 0) || tx_data !== exp_head) begin errors++; $display("FAIL b2b_head i=%0d actual=%b/%h expected=%b/%h", i, tx_valid, tx_data, q.size() != 0, exp_head); end
      op = $urandom_range(0, 9);
      if (op < 5) cycle(1, 16'hFF04, 16'($urandom), 1'($urandom));
      else if (op == 5) cycle(1, 16'hFF05, 16'($urandom), 1'($urandom));
      else cycle(0, 16'h0000, 16'h0000, 1'($urandom));
      dmem_addr = 16'hFF05; #1;
      checks++; if (dmem_din !== exp_read(16'hFF05)) begin errors++; $display("FAIL b2b_status i=%0d actual=%h expected=%h", i, dmem_din, exp_read(16'hFF05)); end
    end
    while (q.size() != 0) cycle(0, 16'h0000, 16'h0000, 1);
    cycle(1, 16'hFF05, 16'h0004, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, 16'hFF04, 16'($urandom), 0);
    cycle(1, 16'hFF00, 16'h1234, 0);
    cycle(1, 16'hFF02, 16'h0100, 0);
    cycle(1, 16'hFF03, 16'h0001, 0);
    cycle(0, 16'h0000, 16'h0000, 1);
    #2 n_rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin errors++; $display("FAIL midrst_tx actual=%b/%h expected=0/0000", tx_valid, tx_data); end
    checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL midrst_gpio actual=%h expected=0000", gpio_out); end
    dmem_addr = 16'hFF02; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL midrst_cnt actual=%h expected=0000", dmem_din); end
    model_reset();
    tx_ready = 1'b0;
    @(posedge clock);
    #3 n_rst = 1'b1;
    #1;
    dmem_addr = 16'hFF05; #1;
    checks++; if (dmem_din !== 16'h0002) begin errors++; $display("FAIL midrst_status actual=%h expected=0002", dmem_din); end
    dmem_addr = 16'hFF03; #1;
    checks++; if (dmem_din !== 16'h0000) begin errors++; $display("FAIL midrst_ctrl actual=%h expected=0000", dmem_din); end
    dmem_addr = 16'h0005; #1;
    checks++; if (dmem_din !== exp_read(16'h0005)) begin errors++; $display("FAIL ram_survives_rst actual=%h expected=%h", dmem_din, exp_read(16'h0005)); end
    cycle(0, 16'h0000, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_fifo_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
